// File: rtl/mac_rx_pkg.sv
// Shared definitions for the MII receive path.
//
// Contents:
//   rx_state_t      - receive FSM states (IDLE, PRE, LOW, HIGH, DROP)
//   PREAMBLE_NIB    - preamble nibble value (0x5)
//   SFD_NIB         - start-of-frame-delimiter nibble value (0xD)
//   DEFAULT_MAX_LEN - largest legal frame in bytes after the SFD
//   LEN_W           - width of the per-frame byte counter
//   len_sat_inc     - saturating increment for the byte counter
package mac_rx_pkg;

  localparam int LEN_W           = 11;
  localparam int DEFAULT_MAX_LEN = 1522;

  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_LOW,
    ST_HIGH,
    ST_DROP
  } rx_state_t;

  // Byte counter holds at all-ones so frame_len never wraps on giant frames.
  function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/mac_sat_counter.sv
// Saturating statistics counter.
//
// Ports:
//   clock - counter clock
//   reset - synchronous, active-low reset (clears the count)
//   inc   - increment request for this cycle
//   count - current value; sticks at all-ones instead of wrapping
module mac_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Increment only while below all-ones so the statistic never wraps.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mii_rx_nibble_packer.sv
// MII receive nibble packer.
//
// Registers the MII receive pads, hunts and strips the preamble/SFD,
// assembles nibbles low-nibble-first into bytes and emits a framed byte
// stream. One byte is always held back in a pending buffer because the last
// byte of a frame is only known once rx_dv falls.
//
// Ports:
//   clock       - MII receive clock
//   reset       - synchronous, active-low reset
//   mii_rxd     - receive nibble from pad
//   mii_rx_dv   - receive data valid from pad
//   mii_rx_er   - receive error from pad
//   out_valid   - one-cycle strobe qualifying out_data/out_sof/out_eof/out_err
//   out_data    - assembled byte {high nibble, low nibble}
//   out_sof     - first byte after the SFD
//   out_eof     - last byte of the frame
//   out_err     - with out_eof: frame bad (rx_er, dribble nibble, oversize)
//   frame_len   - saturated byte count of the frame, valid with out_eof
//   cnt_ok      - good frames
//   cnt_err     - bad frames (rx_er, oversize, false carrier, zero length)
//   cnt_dribble - frames that ended on an odd nibble
module mii_rx_nibble_packer
  import mac_rx_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       mii_rxd,
  input  logic             mii_rx_dv,
  input  logic             mii_rx_er,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_err,
  output logic [LEN_W-1:0] frame_len,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err,
  output logic [CNT_W-1:0] cnt_dribble
);

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  logic [3:0]       rxd_q;
  logic             dv_q;
  logic             er_q;

  rx_state_t        state;
  rx_state_t        state_next;

  logic [3:0]       lo_nib;
  logic             er_acc;
  logic [7:0]       pend_data;
  logic             pend_full;
  logic             sof_pend;
  logic             frame_err;
  logic [LEN_W-1:0] byte_cnt;

  logic [7:0]       new_byte;
  logic [LEN_W-1:0] byte_cnt_inc;
  logic             oversize;

  logic             emit;
  logic             emit_eof;
  logic             emit_err;
  logic             take_lo;
  logic             load_byte;
  logic             start_frame;
  logic             clear_frame;
  logic             inc_ok;
  logic             inc_err;
  logic             inc_dribble;

  assign new_byte     = {rxd_q, lo_nib};
  assign byte_cnt_inc = len_sat_inc(byte_cnt);
  assign oversize     = (byte_cnt_inc > MAX_LEN_V);

  // The pads are registered once; everything downstream sees only these.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rxd_q <= '0;
      dv_q  <= 1'b0;
      er_q  <= 1'b0;
    end else begin
      rxd_q <= mii_rxd;
      dv_q  <= mii_rx_dv;
      er_q  <= mii_rx_er;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle actions. A fall of dv while in HIGH is always
  // a dribble frame, regardless of er on that cycle.
  always_comb begin
    state_next  = state;
    emit        = 1'b0;
    emit_eof    = 1'b0;
    emit_err    = 1'b0;
    take_lo     = 1'b0;
    load_byte   = 1'b0;
    start_frame = 1'b0;
    clear_frame = 1'b0;
    inc_ok      = 1'b0;
    inc_err     = 1'b0;
    inc_dribble = 1'b0;

    case (state)
      ST_IDLE: begin
        clear_frame = 1'b1;
        if (dv_q) begin
          if (rxd_q == PREAMBLE_NIB) begin
            state_next = ST_PRE;
          end else begin
            state_next = ST_DROP;
            inc_err    = 1'b1;
          end
        end
      end

      ST_PRE: begin
        if (!dv_q) begin
          state_next = ST_IDLE;
        end else if (rxd_q == PREAMBLE_NIB) begin
          state_next = ST_PRE;
        end else if (rxd_q == SFD_NIB) begin
          state_next  = ST_LOW;
          start_frame = 1'b1;
        end else begin
          state_next = ST_DROP;
          inc_err    = 1'b1;
        end
      end

      ST_LOW: begin
        if (dv_q) begin
          take_lo    = 1'b1;
          state_next = ST_HIGH;
        end else begin
          state_next = ST_IDLE;
          if (pend_full) begin
            emit     = 1'b1;
            emit_eof = 1'b1;
            emit_err = frame_err;
            inc_ok   = !frame_err;
            inc_err  = frame_err;
          end else begin
            inc_err = 1'b1;
          end
        end
      end

      ST_HIGH: begin
        if (dv_q) begin
          load_byte  = 1'b1;
          emit       = pend_full;
          state_next = ST_LOW;
        end else begin
          emit        = pend_full;
          emit_eof    = pend_full;
          emit_err    = pend_full;
          inc_dribble = 1'b1;
          state_next  = ST_IDLE;
        end
      end

      ST_DROP: begin
        if (!dv_q) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: pending buffer, frame bookkeeping and registered outputs.
  // out_data and frame_len hold their last value between strobes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;
      frame_len <= '0;
      lo_nib    <= '0;
      er_acc    <= 1'b0;
      pend_data <= '0;
      pend_full <= 1'b0;
      sof_pend  <= 1'b0;
      frame_err <= 1'b0;
      byte_cnt  <= '0;
    end else begin
      out_valid <= emit;
      out_sof   <= emit & sof_pend;
      out_eof   <= emit_eof;
      out_err   <= emit_err;

      if (emit) begin
        out_data <= pend_data;
        sof_pend <= 1'b0;
      end

      if (emit_eof) begin
        frame_len <= byte_cnt;
      end

      if (clear_frame) begin
        pend_full <= 1'b0;
        sof_pend  <= 1'b0;
        frame_err <= 1'b0;
        er_acc    <= 1'b0;
      end

      if (start_frame) begin
        byte_cnt  <= '0;
        sof_pend  <= 1'b1;
        pend_full <= 1'b0;
        frame_err <= 1'b0;
      end

      if (take_lo) begin
        lo_nib <= rxd_q;
        er_acc <= er_q;
      end

      // Oversize is judged on the count including the byte being loaded.
      if (load_byte) begin
        pend_data <= new_byte;
        pend_full <= 1'b1;
        byte_cnt  <= byte_cnt_inc;
        frame_err <= frame_err | er_acc | er_q | oversize;
      end
    end
  end

  mac_sat_counter #(.CNT_W(CNT_W)) u_cnt_ok (
    .clock (clock),
    .reset (reset),
    .inc   (inc_ok),
    .count (cnt_ok)
  );

  mac_sat_counter #(.CNT_W(CNT_W)) u_cnt_err (
    .clock (clock),
    .reset (reset),
    .inc   (inc_err),
    .count (cnt_err)
  );

  mac_sat_counter #(.CNT_W(CNT_W)) u_cnt_dribble (
    .clock (clock),
    .reset (reset),
    .inc   (inc_dribble),
    .count (cnt_dribble)
  );

endmodule

// File: tb/tb_mii_rx_nibble_packer.sv
// Self-checking bench for mii_rx_nibble_packer.
//
// Frames are described as a byte list plus error/dribble options; a
// frame-level model turns each description into the expected output bytes
// and statistics, and a monitor compares every out_valid strobe against it.
module tb_mii_rx_nibble_packer;

  localparam int MAX_LEN = 1522;
  localparam int CNT_W   = 16;

  typedef struct packed {
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic        err;
    logic [10:0] len;
  } exp_t;

  logic             clock;
  logic             reset;
  logic [3:0]       mii_rxd;
  logic             mii_rx_dv;
  logic             mii_rx_er;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_sof;
  logic             out_eof;
  logic             out_err;
  logic [10:0]      frame_len;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_err;
  logic [CNT_W-1:0] cnt_dribble;

  exp_t       exp_q[$];
  logic [7:0] frame_data[$];
  int         exp_ok;
  int         exp_err;
  int         exp_drib;
  int         num_checks;
  int         num_fail;

  mii_rx_nibble_packer #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .mii_rxd     (mii_rxd),
    .mii_rx_dv   (mii_rx_dv),
    .mii_rx_er   (mii_rx_er),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .out_err     (out_err),
    .frame_len   (frame_len),
    .cnt_ok      (cnt_ok),
    .cnt_err     (cnt_err),
    .cnt_dribble (cnt_dribble)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Monitor: every strobe must match the next expected byte.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_valid", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("out_data", 32'(out_data), 32'(e.data));
        check_output("out_sof", 32'(out_sof), 32'(e.sof));
        check_output("out_eof", 32'(out_eof), 32'(e.eof));
        check_output("out_err", 32'(out_err), 32'(e.err));
        if (e.eof) begin
          check_output("frame_len", 32'(frame_len), 32'(e.len));
        end
      end
    end
  end

  task automatic drive_nib(input logic [3:0] d, input logic dv, input logic er);
    @(negedge clock);
    mii_rxd   = d;
    mii_rx_dv = dv;
    mii_rx_er = er;
  endtask

  task automatic check_counters(input string tag);
    check_output({tag, "_cnt_ok"}, 32'(cnt_ok), 32'(exp_ok));
    check_output({tag, "_cnt_err"}, 32'(cnt_err), 32'(exp_err));
    check_output({tag, "_cnt_dribble"}, 32'(cnt_dribble), 32'(exp_drib));
  endtask

  // Frame-level reference: all n bytes come out in order, the frame is bad
  // on any data-nibble error, a dribble nibble or more than MAX_LEN bytes.
  task automatic model_frame(input int n, input int er_idx, input bit dribble);
    exp_t e;
    bit   bad;
    bad = dribble || (er_idx >= 0) || (n > MAX_LEN);
    for (int i = 0; i < n; i++) begin
      e.data = frame_data[i];
      e.sof  = (i == 0);
      e.eof  = (i == n - 1);
      e.err  = e.eof ? bad : 1'b0;
      e.len  = (n > 2047) ? 11'd2047 : 11'(n);
      exp_q.push_back(e);
    end
    if (dribble)     exp_drib++;
    else if (n == 0) exp_err++;
    else if (bad)    exp_err++;
    else             exp_ok++;
  endtask

  // Sends preamble, SFD, frame_data[0..n-1] low nibble first, an optional
  // dribble nibble, then an idle gap; er_idx selects one data nibble to
  // carry rx_er (-1 for none).
  task automatic apply_stimulus(input string tag, input int pre_len, input int n,
                                input int er_idx, input bit dribble);
    logic [7:0] b;
    model_frame(n, er_idx, dribble);
    for (int i = 0; i < pre_len; i++) drive_nib(4'h5, 1'b1, 1'b0);
    drive_nib(4'hD, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      b = frame_data[i];
      drive_nib(b[3:0], 1'b1, (er_idx == 2 * i));
      drive_nib(b[7:4], 1'b1, (er_idx == 2 * i + 1));
    end
    if (dribble) drive_nib(4'($urandom_range(0, 15)), 1'b1, (er_idx == 2 * n));
    repeat (5) drive_nib(4'h0, 1'b0, 1'b0);
    check_counters(tag);
    check_output({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_frame(input int n, input bit incrementing);
    frame_data.delete();
    for (int i = 0; i < n; i++) begin
      frame_data.push_back(incrementing ? 8'(i) : 8'($urandom_range(0, 255)));
    end
  endtask

  task automatic set_abc();
    frame_data.delete();
    frame_data.push_back(8'h11);
    frame_data.push_back(8'h22);
    frame_data.push_back(8'h33);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int   n;
    int   nibs;
    int   er_idx;
    bit   drib;
    num_checks = 0;
    num_fail   = 0;
    exp_ok     = 0;
    exp_err    = 0;
    exp_drib   = 0;
    reset      = 1'b0;
    mii_rxd    = 4'h0;
    mii_rx_dv  = 1'b0;
    mii_rx_er  = 1'b0;

    repeat (3) @(negedge clock);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_out_data", 32'(out_data), 32'd0);
    check_output("reset_frame_len", 32'(frame_len), 32'd0);
    check_counters("reset");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    $display("[TB] basic frame 11 22 33");
    set_abc();
    apply_stimulus("basic", 15, 3, -1, 1'b0);

    $display("[TB] rx_er on low nibble of 0x22");
    set_abc();
    apply_stimulus("rx_er", 15, 3, 2, 1'b0);

    $display("[TB] dribble nibble");
    set_abc();
    apply_stimulus("dribble", 15, 3, -1, 1'b1);

    $display("[TB] false carrier then good frame");
    repeat (10) drive_nib(4'hA, 1'b1, 1'b0);
    repeat (5) drive_nib(4'h0, 1'b0, 1'b0);
    exp_err++;
    check_counters("false_carrier");
    set_abc();
    apply_stimulus("after_fc", 7, 3, -1, 1'b0);

    $display("[TB] zero-length frame and one-nibble dribble");
    apply_stimulus("zero_len", 4, 0, -1, 1'b0);
    apply_stimulus("nibble_only", 3, 0, -1, 1'b1);

    $display("[TB] MAX_LEN and MAX_LEN+1 frames");
    fill_frame(MAX_LEN, 1'b1);
    apply_stimulus("max_len", 15, MAX_LEN, -1, 1'b0);
    fill_frame(MAX_LEN + 1, 1'b1);
    apply_stimulus("oversize", 15, MAX_LEN + 1, -1, 1'b0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 30; f++) begin
      n    = $urandom_range(0, 40);
      drib = ($urandom_range(0, 3) == 0);
      nibs = 2 * n + (drib ? 1 : 0);
      er_idx = (nibs > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, nibs - 1)) : -1;
      fill_frame(n, 1'b0);
      apply_stimulus("random", $urandom_range(1, 15), n, er_idx, drib);
    end

    $display("[TB] reset mid-frame");
    fill_frame(5, 1'b0);
    // Bytes 0..3 leave before the reset; byte 4 is still pending.
    for (int i = 0; i < 4; i++) begin
      e.data = frame_data[i];
      e.sof  = (i == 0);
      e.eof  = 1'b0;
      e.err  = 1'b0;
      e.len  = 11'd0;
      exp_q.push_back(e);
    end
    repeat (15) drive_nib(4'h5, 1'b1, 1'b0);
    drive_nib(4'hD, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_nib(frame_data[i][3:0], 1'b1, 1'b0);
      drive_nib(frame_data[i][7:4], 1'b1, 1'b0);
    end
    drive_nib(4'h7, 1'b1, 1'b0);
    @(negedge clock);
    reset     = 1'b0;
    mii_rx_dv = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    exp_ok   = 0;
    exp_err  = 0;
    exp_drib = 0;
    repeat (3) @(negedge clock);
    check_counters("mid_reset");
    check_output("mid_reset_drained", 32'(exp_q.size()), 32'd0);
    set_abc();
    apply_stimulus("post_reset", 15, 3, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
